weight_stream_receiver: RTL and testbench

WEIGHT_STREAM_RECEIVER -- requirements
Module: weight_stream_receiver

---
 rtl/weight_stream_receiver.sv | 86 ++++++++
 tb/tb_weight_stream_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_receiver.sv
// Coefficient buffer loader: pops MEM_SIZE words from an upstream FIFO into a
// local kernel buffer, then serves registered reads to the compute engine.
module weight_stream_receiver #(
  parameter int MEM_SIZE   = 9,
  parameter int DATA_WIDTH = 16,
  localparam int ADDR_W    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DATA_WIDTH-1:0] input_V_dout,
  input  logic                  input_V_empty_n,
  output logic                  input_V_read,
  input  logic [ADDR_W-1:0]     weight_V_address0,
  input  logic                  weight_V_ce0,
  output logic [DATA_WIDTH-1:0] weight_V_q0,
  input  logic                  reload,
  output logic                  ready,
  output logic                  load_done
);

  localparam logic [0:0] S_LOAD  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W:0]   LP_SIZE = (ADDR_W + 1)'(MEM_SIZE);

  logic [0:0]            r_state;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic                  r_load_done;
  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] r_q0_p1;

  logic w_pop;
  logic w_last;
  logic w_addr_ok;

  // Reset gates the strobe so no word is consumed in a reset cycle.
  assign w_pop        = (r_state == S_LOAD) && input_V_empty_n && !ap_rst;
  assign w_last       = (r_wr_ptr == LP_LAST);
  assign w_addr_ok    = ({1'b0, weight_V_address0} < LP_SIZE);
  assign input_V_read = w_pop;
  assign ready        = (r_state == S_READY);
  assign load_done    = r_load_done;
  assign weight_V_q0  = r_q0_p1;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= S_LOAD;
      r_wr_ptr    <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_pop) begin
            if (w_last) begin
              r_wr_ptr    <= '0;
              r_state     <= S_READY;
              r_load_done <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        default: begin
          if (reload) r_state <= S_LOAD;
        end
      endcase
    end
  end

  // Buffer contents survive reset; only the fill pointer restarts.
  always_ff @(posedge ap_clk) begin
    if (w_pop) r_mem[r_wr_ptr] <= input_V_dout;
  end

  // Read stage p1: nonblocking update gives read-first on a same-address write.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_q0_p1 <= '0;
    end else if (weight_V_ce0) begin
      r_q0_p1 <= w_addr_ok ? r_mem[weight_V_address0] : '0;
    end
  end

endmodule

// File: tb/tb_weight_stream_receiver.sv
// Bench for weight_stream_receiver: fills, refills, reset mid-fill and read
// port behaviour, with read results checked through an expected-value queue.
module tb_weight_stream_receiver;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [15:0] input_V_dout;
  logic        input_V_empty_n;
  logic        input_V_read;
  logic [3:0]  weight_V_address0;
  logic        weight_V_ce0;
  logic [15:0] weight_V_q0;
  logic        reload;
  logic        ready;
  logic        load_done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  weight_stream_receiver #(.MEM_SIZE(9), .DATA_WIDTH(16)) dut (
    .ap_clk            (ap_clk),
    .ap_rst            (ap_rst),
    .input_V_dout      (input_V_dout),
    .input_V_empty_n   (input_V_empty_n),
    .input_V_read      (input_V_read),
    .weight_V_address0 (weight_V_address0),
    .weight_V_ce0      (weight_V_ce0),
    .weight_V_q0       (weight_V_q0),
    .reload            (reload),
    .ready             (ready),
    .load_done         (load_done)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Read monitor: a ce0 sampled on an edge yields data checked just after it.
  always begin
    logic ce_seen;
    logic rst_seen;
    int   e;
    @(posedge ap_clk);
    ce_seen  = weight_V_ce0;
    rst_seen = ap_rst;
    #1;
    if (ce_seen && !rst_seen) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rd_q0", 32'(weight_V_q0), 32'(e));
      end
    end
  end

  // Streams words base, base+1, ... until n_words pops are seen or budget expires.
  task automatic fill(input int base, input bit toggle, input int n_words,
                      input int reload_cyc, output int pops, output int dones);
    bit phase = 1'b1;
    int cyc = 0;
    pops  = 0;
    dones = 0;
    while (pops < n_words && cyc < 100) begin
      @(negedge ap_clk);
      if (load_done) dones++;
      chk("rdy_in_fill", 32'(ready), 32'd0);
      input_V_empty_n = toggle ? phase : 1'b1;
      phase           = ~phase;
      input_V_dout    = 16'(base + pops);
      reload          = (cyc == reload_cyc);
      #1;
      if (input_V_read && input_V_empty_n) pops++;
      cyc++;
    end
    @(posedge ap_clk);
    #1;
    input_V_empty_n = 1'b0;
    reload          = 1'b0;
  endtask

  // Checks the cycle after the final pop and that no further pops are accepted.
  task automatic post_fill(input int pops, input int dones);
    chk("pop_count", 32'(pops), 32'd9);
    chk("done_early", 32'(dones), 32'd0);
    @(negedge ap_clk);
    chk("rdy_after_fill", 32'(ready), 32'd1);
    chk("done_pulse", 32'(load_done), 32'd1);
    input_V_empty_n = 1'b1;
    #1;
    chk("no_extra_pop", 32'(input_V_read), 32'd0);
    @(negedge ap_clk);
    chk("done_cleared", 32'(load_done), 32'd0);
    chk("rdy_held", 32'(ready), 32'd1);
    input_V_empty_n = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge ap_clk);
    chk("rdy_pre_reload", 32'(ready), 32'd1);
    reload = 1'b1;
    @(negedge ap_clk);
    reload = 1'b0;
    chk("rdy_fall", 32'(ready), 32'd0);
  endtask

  task automatic rd(input int addr, input int exp);
    @(negedge ap_clk);
    weight_V_ce0      = 1'b1;
    weight_V_address0 = 4'(addr);
    exp_q.push_back(exp);
  endtask

  task automatic rd_idle();
    @(negedge ap_clk);
    weight_V_ce0 = 1'b0;
    @(negedge ap_clk);
  endtask

  initial begin
    int pops;
    int dones;
    ap_rst = 1'b1;
    input_V_dout = '0;
    input_V_empty_n = 1'b1;
    weight_V_address0 = '0;
    weight_V_ce0 = 1'b0;
    reload = 1'b0;
    repeat (3) @(negedge ap_clk);
    #1;
    chk("rst_read", 32'(input_V_read), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_q0", 32'(weight_V_q0), 32'd0);
    ap_rst = 1'b0;
    input_V_empty_n = 1'b0;

    // back-to-back fill of 1..9
    fill(1, 1'b0, 9, -1, pops, dones);
    post_fill(pops, dones);
    for (int a = 0; a < 9; a++) rd(a, a + 1);
    rd_idle();

    // refill 1..9 with a stalling source
    do_reload();
    fill(1, 1'b1, 9, -1, pops, dones);
    post_fill(pops, dones);
    for (int a = 8; a >= 0; a--) rd(a, a + 1);
    rd_idle();

    // refill 11..19 with a reload pulse mid-fill that must be ignored
    do_reload();
    fill(11, 1'b0, 9, 3, pops, dones);
    post_fill(pops, dones);
    rd(4, 15);
    rd_idle();
    repeat (3) begin
      @(negedge ap_clk);
      chk("q0_hold", 32'(weight_V_q0), 32'd15);
    end
    rd(12, 0);
    rd_idle();
    repeat (3) begin
      @(negedge ap_clk);
      chk("q0_hold_oor", 32'(weight_V_q0), 32'd0);
    end
    rd(0, 11);
    rd(8, 19);
    rd_idle();

    // reset after 5 pops, then fill 21..29
    do_reload();
    fill(31, 1'b0, 5, -1, pops, dones);
    chk("partial_pops", 32'(pops), 32'd5);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    input_V_empty_n = 1'b1;
    input_V_dout = 16'd999;
    reload = 1'b1;
    #1;
    chk("rst_mid_read", 32'(input_V_read), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    @(negedge ap_clk);
    chk("rst_mid_ready2", 32'(ready), 32'd0);
    chk("rst_mid_done", 32'(load_done), 32'd0);
    ap_rst = 1'b0;
    reload = 1'b0;
    input_V_empty_n = 1'b0;
    fill(21, 1'b0, 9, -1, pops, dones);
    post_fill(pops, dones);
    rd(0, 21);
    rd(8, 29);
    rd(5, 26);
    rd_idle();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
